// File: rtl/vga_timing_gen.sv
// Two-axis VGA timing generator: H/V counters advanced by a pixel-rate enable,
// with registered sync, active-video, position, line/frame strobes and a frame counter.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter logic        HSYNC_POL = 1'b0,
  parameter logic        VSYNC_POL = 1'b0,
  parameter int unsigned XW        = 10,
  parameter int unsigned YW        = 10,
  parameter int unsigned FCW       = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pixel_tick,
  input  logic           restart,
  output logic           hsync,
  output logic           vsync,
  output logic           hvideo_on,
  output logic           vvideo_on,
  output logic           video_on,
  output logic [XW-1:0]  x_pos,
  output logic [XW-1:0]  x_pos_next,
  output logic [YW-1:0]  y_pos,
  output logic           eol,
  output logic           eof,
  output logic [FCW-1:0] frame_count
);

  localparam int unsigned H_TOTAL = H_BP + H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned V_TOTAL = V_BP + V_ACTIVE + V_FP + V_SYNC;
  localparam int unsigned HCW     = $clog2(H_TOTAL);
  localparam int unsigned VCW     = $clog2(V_TOTAL);

  // Segment boundaries in counter units; active end is exclusive.
  localparam logic [HCW-1:0] H_LAST       = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_ACT_START  = HCW'(H_BP);
  localparam logic [HCW-1:0] H_ACT_END    = HCW'(H_BP + H_ACTIVE);
  localparam logic [HCW-1:0] H_SYNC_START = HCW'(H_BP + H_ACTIVE + H_FP);
  localparam logic [VCW-1:0] V_LAST       = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_ACT_START  = VCW'(V_BP);
  localparam logic [VCW-1:0] V_ACT_END    = VCW'(V_BP + V_ACTIVE);
  localparam logic [VCW-1:0] V_SYNC_START = VCW'(V_BP + V_ACTIVE + V_FP);

  if ((H_ACTIVE > (1 << XW)) || (V_ACTIVE > (1 << YW)) ||
      (H_ACTIVE == 0) || (H_FP == 0) || (H_SYNC == 0) || (H_BP == 0) ||
      (V_ACTIVE == 0) || (V_FP == 0) || (V_SYNC == 0) || (V_BP == 0)) begin : g_param_check
    $error("vga_timing_gen: illegal timing parameters");
  end

  logic [HCW-1:0] h_cnt;
  logic [VCW-1:0] v_cnt;

  logic           h_video_c;
  logic           v_video_c;
  logic           h_sync_act_c;
  logic           v_sync_act_c;
  logic           h_last_c;
  logic           v_last_c;
  logic [XW-1:0]  x_c;
  logic [YW-1:0]  y_c;

  // Decode of the current (pre-increment) counter position.
  always_comb begin
    h_video_c    = (h_cnt >= H_ACT_START) && (h_cnt < H_ACT_END);
    v_video_c    = (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END);
    h_sync_act_c = (h_cnt >= H_SYNC_START);
    v_sync_act_c = (v_cnt >= V_SYNC_START);
    h_last_c     = (h_cnt == H_LAST);
    v_last_c     = (v_cnt == V_LAST);
    x_c          = '0;
    y_c          = '0;
    if (h_video_c) x_c = XW'(h_cnt - H_ACT_START);
    if (v_video_c) y_c = YW'(v_cnt - V_ACT_START);
  end

  assign x_pos_next = x_c;

  // Position counters; restart overrides the pixel tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (restart) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pixel_tick) begin
      h_cnt <= h_last_c ? '0 : h_cnt + HCW'(1);
      if (h_last_c) begin
        v_cnt <= v_last_c ? '0 : v_cnt + VCW'(1);
      end
    end
  end

  // Registered outputs; restart returns them to idle without touching frame_count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      hvideo_on   <= 1'b0;
      vvideo_on   <= 1'b0;
      video_on    <= 1'b0;
      x_pos       <= '0;
      y_pos       <= '0;
      eol         <= 1'b0;
      eof         <= 1'b0;
      frame_count <= '0;
    end else if (restart) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      hvideo_on   <= 1'b0;
      vvideo_on   <= 1'b0;
      video_on    <= 1'b0;
      x_pos       <= '0;
      y_pos       <= '0;
      eol         <= 1'b0;
      eof         <= 1'b0;
    end else if (pixel_tick) begin
      hsync     <= h_sync_act_c ? HSYNC_POL : ~HSYNC_POL;
      vsync     <= v_sync_act_c ? VSYNC_POL : ~VSYNC_POL;
      hvideo_on <= h_video_c;
      vvideo_on <= v_video_c;
      video_on  <= h_video_c & v_video_c;
      x_pos     <= x_c;
      y_pos     <= y_c;
      eol       <= h_last_c;
      eof       <= h_last_c & v_last_c;
      if (h_last_c && v_last_c) begin
        frame_count <= frame_count + FCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameterisations checked every cycle against an
// arithmetic position model, plus directed line/frame/restart/tick-rate sequences.
module tb_vga_timing_gen;

  // Instance 0: 640x480 defaults, 1: mid-size frame, 2: tiny frame with high polarity.
  localparam int HA[3]    = '{640, 16, 4};
  localparam int HF[3]    = '{16, 2, 1};
  localparam int HS[3]    = '{96, 3, 1};
  localparam int HB[3]    = '{48, 4, 1};
  localparam int VA[3]    = '{480, 12, 2};
  localparam int VF[3]    = '{10, 2, 1};
  localparam int VS[3]    = '{2, 2, 1};
  localparam int VB[3]    = '{33, 3, 1};
  localparam bit HPOL[3]  = '{1'b0, 1'b0, 1'b1};
  localparam bit VPOL[3]  = '{1'b0, 1'b0, 1'b1};
  localparam int FCWS[3]  = '{8, 8, 2};

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       hv;
    logic       vv;
    logic       von;
    logic       eol;
    logic       eof;
    logic [9:0] x;
    logic [9:0] xn;
    logic [9:0] y;
    logic [7:0] fc;
  } obs_t;

  typedef struct {
    int   ticks;
    logic hsync, vsync, hv, von, eol, eof;
    int   x, y, fc;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] tick;
  logic [2:0] rs;

  logic       hs_w[3], vs_w[3], hv_w[3], vv_w[3], von_w[3], eol_w[3], eof_w[3];
  logic [9:0] x_w[3], xn_w[3], y_w[3];
  logic [7:0] fc_w[3];

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: ticks since reset/restart, last decoded position, completed frames.
  int cnt[3];
  int p_out[3];
  int frames[3];
  bit vld[3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned FC = FCWS[g];
    logic [FC-1:0] fc;
    vga_timing_gen #(
      .H_ACTIVE(HA[g]), .H_FP(HF[g]), .H_SYNC(HS[g]), .H_BP(HB[g]),
      .V_ACTIVE(VA[g]), .V_FP(VF[g]), .V_SYNC(VS[g]), .V_BP(VB[g]),
      .HSYNC_POL(HPOL[g]), .VSYNC_POL(VPOL[g]),
      .XW(10), .YW(10), .FCW(FC)
    ) u_dut (
      .clk(clk), .reset(rst), .pixel_tick(tick[g]), .restart(rs[g]),
      .hsync(hs_w[g]), .vsync(vs_w[g]), .hvideo_on(hv_w[g]), .vvideo_on(vv_w[g]),
      .video_on(von_w[g]), .x_pos(x_w[g]), .x_pos_next(xn_w[g]), .y_pos(y_w[g]),
      .eol(eol_w[g]), .eof(eof_w[g]), .frame_count(fc)
    );
    assign fc_w[g] = 8'(fc);
  end

  function automatic int flen(int g);
    return (HB[g] + HA[g] + HF[g] + HS[g]) * (VB[g] + VA[g] + VF[g] + VS[g]);
  endfunction

  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rst) begin
        cnt[g] = 0; p_out[g] = 0; frames[g] = 0; vld[g] = 1'b0;
      end else if (rs[g]) begin
        cnt[g] = 0; vld[g] = 1'b0;
      end else if (tick[g]) begin
        p_out[g] = cnt[g];
        vld[g]   = 1'b1;
        if (cnt[g] == flen(g) - 1) frames[g] = frames[g] + 1;
        cnt[g] = (cnt[g] + 1) % flen(g);
      end
    end
  end

  function automatic obs_t expect_obs(int g);
    obs_t e;
    int ht, vt, h, v, hn;
    ht = HB[g] + HA[g] + HF[g] + HS[g];
    vt = VB[g] + VA[g] + VF[g] + VS[g];
    e = '0;
    e.hsync = ~HPOL[g];
    e.vsync = ~VPOL[g];
    if (vld[g]) begin
      h = p_out[g] % ht;
      v = p_out[g] / ht;
      e.hv  = (h >= HB[g]) && (h < HB[g] + HA[g]);
      e.vv  = (v >= VB[g]) && (v < VB[g] + VA[g]);
      e.von = e.hv & e.vv;
      if (h >= HB[g] + HA[g] + HF[g]) e.hsync = HPOL[g];
      if (v >= VB[g] + VA[g] + VF[g]) e.vsync = VPOL[g];
      if (e.hv) e.x = 10'(h - HB[g]);
      if (e.vv) e.y = 10'(v - VB[g]);
      e.eol = (h == ht - 1);
      e.eof = e.eol && (v == vt - 1);
    end
    hn = cnt[g] % ht;
    if ((hn >= HB[g]) && (hn < HB[g] + HA[g])) e.xn = 10'(hn - HB[g]);
    e.fc = 8'(frames[g] % (1 << FCWS[g]));
    return e;
  endfunction

  function automatic obs_t actual_obs(int g);
    obs_t a;
    a.hsync = hs_w[g]; a.vsync = vs_w[g]; a.hv = hv_w[g]; a.vv = vv_w[g];
    a.von = von_w[g]; a.eol = eol_w[g]; a.eof = eof_w[g];
    a.x = x_w[g]; a.xn = xn_w[g]; a.y = y_w[g]; a.fc = fc_w[g];
    return a;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor_all();
    obs_t a, e;
    for (int g = 0; g < 3; g++) begin
      a = actual_obs(g);
      e = expect_obs(g);
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL mon_dut%0d t=%0t got=%h expected=%h", g, $time, a, e);
      end
    end
  endtask

  task automatic cyc(input logic [2:0] tk, input logic [2:0] r);
    tick = tk;
    rs   = r;
    @(posedge clk);
    #1;
    monitor_all();
  endtask

  task automatic do_reset();
    tick = '0;
    rs   = '0;
    rst  = 1'b1;
    #1;
    check("async_reset_hv1", int'(hv_w[1]), 0);
    check("async_reset_fc1", int'(fc_w[1]), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    monitor_all();
  endtask

  initial begin
    vec_t vt[$];
    obs_t prev_o, cur_o;
    int eol_n, hv_n, hs_n, first_hv, x_last, xn_bad, prev_xn;
    int hold_bad, rise0, rise1, eof_n, vs_n, ymax, done, fc_prev;
    logic prev_eol;
    logic [2:0] rtk, rrs;

    rst = 1'b1; tick = '0; rs = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    monitor_all();

    // Reset values: sync idle at the deasserted level of each polarity.
    check("reset_hsync0", int'(hs_w[0]), 1);
    check("reset_vsync0", int'(vs_w[0]), 1);
    check("reset_hsync2", int'(hs_w[2]), 0);
    check("reset_video0", int'(von_w[0]), 0);
    check("reset_fc0",    int'(fc_w[0]), 0);

    // One full default line, a tick every clk.
    eol_n = 0; hv_n = 0; hs_n = 0; first_hv = -1; x_last = -1; xn_bad = 0;
    prev_xn = int'(xn_w[0]);
    for (int i = 0; i < 800; i++) begin
      cyc(3'b001, 3'b000);
      if (int'(x_w[0]) != prev_xn) xn_bad++;
      prev_xn = int'(xn_w[0]);
      if (eol_w[0]) eol_n++;
      if (hv_w[0]) begin
        hv_n++;
        if (first_hv < 0) first_hv = i;
        x_last = int'(x_w[0]);
      end
      if (!hs_w[0]) hs_n++;
    end
    check("line_eol_count", eol_n, 1);
    check("line_hvideo_count", hv_n, 640);
    check("line_hsync_low", hs_n, 96);
    check("line_first_active_tick", first_hv, 48);
    check("line_last_x", x_last, 639);
    check("line_xnext_leads", xn_bad, 0);

    // Restart at h=300, v=2 coincident with a tick.
    for (int i = 0; i < 1100; i++) cyc(3'b001, 3'b000);
    check("pre_restart_x", int'(x_w[0]), 251);
    check("pre_restart_xnext", int'(xn_w[0]), 252);
    fc_prev = int'(fc_w[0]);
    cyc(3'b001, 3'b001);
    check("restart_hsync", int'(hs_w[0]), 1);
    check("restart_hvideo", int'(hv_w[0]), 0);
    check("restart_x", int'(x_w[0]), 0);
    check("restart_xnext", int'(xn_w[0]), 0);
    check("restart_fc_held", int'(fc_w[0]), fc_prev);
    cyc(3'b001, 3'b001);
    cyc(3'b001, 3'b001);
    for (int i = 0; i < 50; i++) cyc(3'b001, 3'b000);
    check("after_restart_x", int'(x_w[0]), 1);

    // Pixel tick every 4th clk: outputs hold between ticks, line = 3200 clks.
    cyc(3'b000, 3'b001);
    hold_bad = 0; rise0 = -1; rise1 = -1;
    prev_o = actual_obs(0);
    prev_eol = eol_w[0];
    for (int i = 0; i < 6600; i++) begin
      cyc((i % 4 == 0) ? 3'b001 : 3'b000, 3'b000);
      cur_o = actual_obs(0);
      if ((i % 4 != 0) && (cur_o !== prev_o)) hold_bad++;
      if (eol_w[0] && !prev_eol) begin
        if (rise0 < 0) rise0 = i;
        else if (rise1 < 0) rise1 = i;
      end
      prev_eol = eol_w[0];
      prev_o = cur_o;
    end
    check("slow_hold_between_ticks", hold_bad, 0);
    check("slow_line_clks", rise1 - rise0, 3200);

    // Full frame on the mid-size instance (25 x 19).
    eof_n = 0; vs_n = 0; ymax = 0;
    for (int i = 0; i < 475; i++) begin
      cyc(3'b010, 3'b000);
      if (eof_w[1]) eof_n++;
      if (!vs_w[1]) vs_n++;
      if (int'(y_w[1]) > ymax) ymax = int'(y_w[1]);
    end
    check("frame_eof_count", eof_n, 1);
    check("frame_fc", int'(fc_w[1]), 1);
    check("frame_vsync_low", vs_n, 50);
    check("frame_ymax", ymax, 11);

    // Tiny instance: line 7 ticks, frame 35 ticks, 2-bit frame counter.
    //       ticks hs vs hv von eol eof  x  y  fc
    vt.push_back('{1,   0, 0, 0, 0, 0, 0, 0, 0, 0});
    vt.push_back('{3,   0, 0, 1, 0, 0, 0, 1, 0, 0});
    vt.push_back('{7,   1, 0, 0, 0, 1, 0, 0, 0, 0});
    vt.push_back('{10,  0, 0, 1, 1, 0, 0, 1, 0, 0});
    vt.push_back('{19,  0, 0, 1, 1, 0, 0, 3, 1, 0});
    vt.push_back('{30,  0, 1, 1, 0, 0, 0, 0, 0, 0});
    vt.push_back('{35,  1, 1, 0, 0, 1, 1, 0, 0, 1});
    vt.push_back('{36,  0, 0, 0, 0, 0, 0, 0, 0, 1});
    vt.push_back('{105, 1, 1, 0, 0, 1, 1, 0, 0, 3});
    vt.push_back('{140, 1, 1, 0, 0, 1, 1, 0, 0, 0});
    vt.push_back('{141, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    done = 0;
    foreach (vt[k]) begin
      while (done < vt[k].ticks) begin
        cyc(3'b100, 3'b000);
        done++;
      end
      check($sformatf("tiny%0d_flags", vt[k].ticks),
            int'({hs_w[2], vs_w[2], hv_w[2], von_w[2], eol_w[2], eof_w[2]}),
            int'({vt[k].hsync, vt[k].vsync, vt[k].hv, vt[k].von, vt[k].eol, vt[k].eof}));
      check($sformatf("tiny%0d_x", vt[k].ticks), int'(x_w[2]), vt[k].x);
      check($sformatf("tiny%0d_y", vt[k].ticks), int'(y_w[2]), vt[k].y);
      check($sformatf("tiny%0d_fc", vt[k].ticks), int'(fc_w[2]), vt[k].fc);
    end

    // Random ticks, restarts and occasional mid-frame resets.
    for (int i = 0; i < 20000; i++) begin
      for (int g = 0; g < 3; g++) begin
        rtk[g] = ($urandom_range(3) != 0);
        rrs[g] = ($urandom_range(99) == 0);
      end
      if ($urandom_range(2999) == 0) do_reset();
      else cyc(rtk, rrs);
    end
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
